// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: widths, register/word types, writeback and destination selects.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;

    // Return-address register written by jal/jalr
    localparam reg_addr_t REG_RA = 5'd31;

    // Writeback data source select
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_DM  = 2'b01,
        WB_PC4 = 2'b10,
        WB_EXT = 2'b11
    } wb_sel_e;

    // Destination register select
    typedef enum logic [1:0] {
        DST_RT = 2'b00,
        DST_RD = 2'b01,
        DST_RA = 2'b10
    } dst_sel_e;

    // Register 0 is hardwired to zero and never tracked
    function automatic logic is_zero_reg(input reg_addr_t a);
        return (a == '0);
    endfunction

endpackage

// File: rtl/ld_scoreboard.sv
// Load-use scoreboard: per-register pending-load countdown, busy vector and stall decode.
// Latency: busy rises the cycle after ld_issue and holds LD_LAT cycles; stall is combinational.
// Backpressure: stall is the hold request to decode; ld_issue is always accepted.
module ld_scoreboard #(
    parameter int AW     = 5,
    parameter int LD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_issue,
    input  logic [AW-1:0]        ld_dst,
    input  logic [AW-1:0]        raddr1,
    input  logic [AW-1:0]        raddr2,
    input  logic                 use1,
    input  logic                 use2,
    output logic                 stall,
    output logic [(1<<AW)-1:0]   busy_vec
);

    localparam int NREG = 1 << AW;
    localparam logic [1:0] LAT = LD_LAT[1:0];

    logic [1:0] cnt_q [NREG];
    logic [1:0] cnt_d [NREG];

    // Countdown every live counter; a new load reloads its destination (newest load wins)
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = (cnt_q[i] != 2'd0) ? cnt_q[i] - 2'd1 : 2'd0;
        end
        if (ld_issue && (ld_dst != '0)) begin
            cnt_d[ld_dst] = LAT;
        end
    end

    // Counter state; reset clears all pending loads asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Busy bits; entry 0 can never be loaded so it stays clear
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            busy_vec[i] = (cnt_q[i] != 2'd0);
        end
    end

    // Hazard only when the consumer really reads the pending operand
    always_comb begin
        stall = (use1 & busy_vec[raddr1]) | (use2 & busy_vec[raddr2]);
    end

endmodule

// File: rtl/regfile_rd_fwd.sv
// 32x32 register file (one write, two combinational reads) with optional write-through bypass
// (REGFILE_WR_BYPASS_EN) and load-use scoreboard. Latency: reads 0 cycles, writes visible next cycle.
// Backpressure: stall asks decode to hold while a read operand has a load in flight.
module regfile_rd_fwd
    import mips_pkg::*;
#(
    parameter int DW     = mips_pkg::DW,
    parameter int AW     = mips_pkg::AW,
    parameter int LD_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DW-1:0]        wdata,
    input  logic [AW-1:0]        raddr1,
    input  logic [AW-1:0]        raddr2,
    output logic [DW-1:0]        rdata1,
    output logic [DW-1:0]        rdata2,
    input  logic                 ld_issue,
    input  logic [AW-1:0]        ld_dst,
    input  logic                 use1,
    input  logic                 use2,
    output logic                 stall,
    output logic [(1<<AW)-1:0]   busy_vec
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic          wr_ok;
    logic          byp1;
    logic          byp2;

    assign wr_ok = we && (waddr != '0);

    // Next register contents; writes to register 0 are dropped
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_ok) begin
            regs_d[waddr] = wdata;
        end
    end

    // Register storage, cleared by asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

`ifdef REGFILE_WR_BYPASS_EN
    // Same-cycle write is forwarded; gated by rst so reads during reset stay 0
    assign byp1 = wr_ok && !rst && (raddr1 == waddr);
    assign byp2 = wr_ok && !rst && (raddr2 == waddr);
`else
    // No forwarding: reads see the pre-edge contents
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // Operand read muxes; register 0 always reads as zero
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) begin
            rdata1 = byp1 ? wdata : regs_q[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2 = byp2 ? wdata : regs_q[raddr2];
        end
    end

    ld_scoreboard #(
        .AW     (AW),
        .LD_LAT (LD_LAT)
    ) u_ld_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .ld_issue (ld_issue),
        .ld_dst   (ld_dst),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .use1     (use1),
        .use2     (use2),
        .stall    (stall),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_regfile_rd_fwd.sv
// Bench for regfile_rd_fwd: directed stimulus pushes expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
// Expectations follow the build: REGFILE_WR_BYPASS_EN selects the bypass result.
module tb_regfile_rd_fwd;
    import mips_pkg::*;

    localparam int K_RD1   = 0;
    localparam int K_RD2   = 1;
    localparam int K_STALL = 2;
    localparam int K_BUSY  = 3;
    localparam int K_BUSYV = 4;

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        ld_issue;
    logic [4:0]  ld_dst;
    logic        use1;
    logic        use2;
    logic        stall;
    logic [31:0] busy_vec;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    regfile_rd_fwd #(.DW(32), .AW(5), .LD_LAT(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .ld_issue (ld_issue),
        .ld_dst   (ld_dst),
        .use1     (use1),
        .use2     (use2),
        .stall    (stall),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation stamped for the current cycle
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.kind)
                K_RD1:   act = rdata1;
                K_RD2:   act = rdata2;
                K_STALL: act = {31'd0, stall};
                K_BUSY:  act = {31'd0, busy_vec[e.idx]};
                default: act = busy_vec;
            endcase
            n_cmp++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input int kind, input int idx, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0;
        ld_issue = 1'b0; ld_dst = '0;
        use1 = 1'b0; use2 = 1'b0;
    endtask

    initial begin
        int wait_cnt;
        rst = 1'b1;
        idle();
        step();
        // Reset state
        raddr1 = 5'd5; raddr2 = 5'd17;
        expect_v(K_RD1, 0, 32'h0, "rst_rd1");
        expect_v(K_RD2, 0, 32'h0, "rst_rd2");
        expect_v(K_STALL, 0, 32'h0, "rst_stall");
        expect_v(K_BUSYV, 0, 32'h0, "rst_busy_vec");
        step();
        rst = 1'b0;
        idle();

        // Fill a couple of registers, then reset mid-run
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
        step();
        we = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
        raddr1 = 5'd3;
        expect_v(K_RD1, 0, 32'hA5A5A5A5, "pre_rst_r3");
        step();
        we = 1'b0;
        raddr2 = 5'd7;
        expect_v(K_RD2, 0, 32'h11111111, "pre_rst_r7");
        step();
        rst = 1'b1;
        expect_v(K_RD2, 0, 32'h0, "rst_async_r7");
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            expect_v(K_RD1, 0, 32'h0, $sformatf("post_rst_rd1_a%0d", i));
            expect_v(K_RD2, 0, 32'h0, $sformatf("post_rst_rd2_a%0d", 31 - i));
            step();
        end

        // Writes to register 0 are dropped, also for the bypass path
        we = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF; raddr1 = 5'd0;
        expect_v(K_RD1, 0, 32'h0, "r0_same_cycle");
        step();
        we = 1'b0;
        expect_v(K_RD1, 0, 32'h0, "r0_after_write");
        step();

        // Write then read of the return-address register
        we = 1'b1; waddr = REG_RA; wdata = 32'h00400004;
        step();
        we = 1'b0; raddr1 = REG_RA;
        expect_v(K_RD1, 0, 32'h00400004, "ra_read");
        step();

        // Same-cycle bypass on rt port
        we = 1'b1; waddr = 5'd8; wdata = 32'hCAFEF00D;
        step();
        we = 1'b1; waddr = 5'd8; wdata = 32'h12345678; raddr2 = 5'd8;
`ifdef REGFILE_WR_BYPASS_EN
        expect_v(K_RD2, 0, 32'h12345678, "bypass_same_cycle");
`else
        expect_v(K_RD2, 0, 32'hCAFEF00D, "no_bypass_old_value");
`endif
        step();
        we = 1'b0;
        expect_v(K_RD2, 0, 32'h12345678, "bypass_next_cycle");
        step();
        idle();

        // Load-use stall, LD_LAT=2
        ld_issue = 1'b1; ld_dst = 5'd9;
        step();
        ld_issue = 1'b0; raddr1 = 5'd9; use1 = 1'b1;
        expect_v(K_STALL, 0, 32'h1, "ld9_stall_c1");
        step();
        expect_v(K_STALL, 0, 32'h1, "ld9_stall_c2");
        step();
        expect_v(K_STALL, 0, 32'h0, "ld9_stall_c3");
        expect_v(K_BUSY, 9, 32'h0, "ld9_busy_c3");
        step();

        // Same load, consumer does not use rs; then rt port uses it
        ld_issue = 1'b1; ld_dst = 5'd9; use1 = 1'b0;
        step();
        ld_issue = 1'b0; raddr1 = 5'd9; use1 = 1'b0;
        expect_v(K_STALL, 0, 32'h0, "ld9_nouse_stall");
        expect_v(K_BUSY, 9, 32'h1, "ld9_nouse_busy");
        step();
        raddr1 = 5'd0; raddr2 = 5'd9; use2 = 1'b1;
        expect_v(K_STALL, 0, 32'h1, "ld9_use2_stall");
        step();
        expect_v(K_STALL, 0, 32'h0, "ld9_use2_clear");
        step();
        idle();

        // Back-to-back loads to register 10
        ld_issue = 1'b1; ld_dst = 5'd10;
        step();
        expect_v(K_BUSY, 10, 32'h1, "b2b_c0");
        step();
        ld_issue = 1'b0;
        expect_v(K_BUSY, 10, 32'h1, "b2b_c1");
        step();
        expect_v(K_BUSY, 10, 32'h1, "b2b_c2");
        step();
        expect_v(K_BUSY, 10, 32'h0, "b2b_c3");
        step();

        // A write to a busy register does not clear its counter
        ld_issue = 1'b1; ld_dst = 5'd12;
        step();
        ld_issue = 1'b0;
        we = 1'b1; waddr = 5'd12; wdata = 32'h0BADF00D;
        step();
        we = 1'b0; raddr1 = 5'd12; use1 = 1'b1;
        expect_v(K_BUSY, 12, 32'h1, "wr_keeps_busy");
        expect_v(K_STALL, 0, 32'h1, "wr_keeps_stall");
        step();
        idle();

        // Load to register 0 never marks it busy
        ld_issue = 1'b1; ld_dst = 5'd0;
        step();
        ld_issue = 1'b0; raddr1 = 5'd0; use1 = 1'b1;
        expect_v(K_BUSYV, 0, 32'h0, "ld0_busy_vec");
        expect_v(K_STALL, 0, 32'h0, "ld0_stall");
        step();
        idle();

        // Reset in the middle of a countdown
        ld_issue = 1'b1; ld_dst = 5'd4;
        step();
        ld_issue = 1'b0; raddr1 = 5'd4; use1 = 1'b1;
        expect_v(K_BUSY, 4, 32'h1, "ld4_busy");
        expect_v(K_STALL, 0, 32'h1, "ld4_stall");
        step();
        rst = 1'b1;
        expect_v(K_BUSY, 4, 32'h0, "ld4_rst_busy");
        expect_v(K_STALL, 0, 32'h0, "ld4_rst_stall");
        step();
        rst = 1'b0;
        expect_v(K_BUSYV, 0, 32'h0, "ld4_after_rst_vec");
        step();
        idle();
        step();

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 100) begin
            step();
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
